// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART controller: register addresses, CON bit
// positions and the TX sequencer state type.
package uart_ctrl_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IE   = 0;
    localparam int CON_RX_IE   = 1;
    localparam int CON_RX_NE   = 2;
    localparam int CON_TX_DONE = 3;
    localparam int CON_TX_BUSY = 4;
    localparam int CON_TX_FULL = 5;
    localparam int CON_RX_OVF  = 6;
    localparam int CON_TX_OVF  = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally. A pop is
// ignored when empty, and a push into a full FIFO succeeds only alongside a pop.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, control/status flags,
// interrupt and the TX start/handshake sequencer.
//   state     | meaning
//   IDLE      | wait for a queued byte and an idle sender; load and pop
//   START     | registered start pulse issued on leaving this state
//   WAIT_ACK  | wait for sender to report busy (status = 0)
//   WAIT_DONE | wait for sender to return idle, then flag tx_done
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    input  logic        uart_tx_status,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid
);

    tx_state_t r_state, w_state_nx;

    logic       r_tx_ie, r_rx_ie, r_tx_done, r_rx_ovf, r_tx_ovf;
    logic [7:0] r_tx_data;
    logic       r_tx_start;

    logic       w_sel_txd, w_sel_rxd, w_sel_con;
    logic       w_tx_push, w_tx_load, w_done_set, w_con_wr, w_rx_pop;
    logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic       w_tx_ovf_set, w_rx_ovf_set, w_tx_busy;
    logic [7:0] w_tx_head, w_rx_head, w_con;
    logic [$clog2(TX_DEPTH):0] w_tx_count;
    logic [$clog2(RX_DEPTH):0] w_rx_count;
    logic       w_unused;

    assign w_sel_txd = (addr == ADDR_TXD);
    assign w_sel_rxd = (addr == ADDR_RXD);
    assign w_sel_con = (addr == ADDR_CON);
    assign w_tx_push = mem_wr && w_sel_txd;
    assign w_con_wr  = mem_wr && w_sel_con;
    assign w_rx_pop  = mem_rd && w_sel_rxd && !w_rx_empty;

    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_load;
    assign w_rx_ovf_set = uart_rx_valid && w_rx_full && !w_rx_pop;
    assign w_tx_busy    = !w_tx_empty || (r_state != IDLE);

    assign w_unused = ^{wdata[31:8], w_tx_count, w_rx_count};

    uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_push  (w_tx_push),
        .i_data  (wdata[7:0]),
        .i_pop   (w_tx_load),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_push  (uart_rx_valid),
        .i_data  (uart_rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_state_nx = r_state;
        w_tx_load  = 1'b0;
        w_done_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_tx_empty && uart_tx_status) begin
                    w_tx_load  = 1'b1;
                    w_state_nx = START;
                end
            end
            START:     w_state_nx = WAIT_ACK;
            WAIT_ACK:  if (!uart_tx_status) w_state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (uart_tx_status) begin
                    w_done_set = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default:   w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tx_start <= (r_state == START);
            if (w_tx_load) r_tx_data <= w_tx_head;
            if (w_con_wr) begin
                r_tx_ie <= wdata[CON_TX_IE];
                r_rx_ie <= wdata[CON_RX_IE];
            end
            // Hardware set takes priority over a coincident W1C clear.
            r_tx_done <= w_done_set   || (r_tx_done && !(w_con_wr && wdata[CON_TX_DONE]));
            r_rx_ovf  <= w_rx_ovf_set || (r_rx_ovf  && !(w_con_wr && wdata[CON_RX_OVF]));
            r_tx_ovf  <= w_tx_ovf_set || (r_tx_ovf  && !(w_con_wr && wdata[CON_TX_OVF]));
        end
    end

    always_comb begin
        w_con              = '0;
        w_con[CON_TX_IE]   = r_tx_ie;
        w_con[CON_RX_IE]   = r_rx_ie;
        w_con[CON_RX_NE]   = !w_rx_empty;
        w_con[CON_TX_DONE] = r_tx_done;
        w_con[CON_TX_BUSY] = w_tx_busy;
        w_con[CON_TX_FULL] = w_tx_full;
        w_con[CON_RX_OVF]  = r_rx_ovf;
        w_con[CON_TX_OVF]  = r_tx_ovf;
    end

    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            if (w_sel_rxd && !w_rx_empty) rdata = {24'b0, w_rx_head};
            else if (w_sel_con)           rdata = {24'b0, w_con};
        end
    end

    assign irq           = (r_rx_ie && !w_rx_empty) || (r_tx_ie && r_tx_done);
    assign uart_tx_data  = r_tx_data;
    assign uart_tx_start = r_tx_start;

endmodule
